// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one prescaled period counter (edge/center aligned).
// Latency: sout is registered one clk after cnt; period_start is one clk after the boundary tick.
// Backpressure: none. Duty writes are always accepted and staged in shadow registers until a period boundary.
module pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  center,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   sout,
  output logic                  period_start
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;      // 0 = counting up, 1 = counting down
  logic [WIDTH-1:0]      shadow_q [CHANNELS];
  logic [WIDTH-1:0]      active_q [CHANNELS];
  logic [CHANNELS-1:0]   sout_q;
  logic                  period_start_q;
  logic                  tick;
  logic                  boundary;
  logic                  wr_ok;

  // Prescaler tick; >= lets a lowered prescale wrap on the very next clk.
  assign tick = en && (pre_cnt_q >= prescale);

  // Every period ends with cnt returning to 0 (P=0 keeps it at 0, so every tick qualifies).
  assign boundary = tick && (cnt_d == '0);

  // Out-of-range channel indices are dropped rather than aliased.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(CHANNELS));

  // Next-state for prescaler, period counter and direction.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (!en) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = 1'b0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (!center) begin
        dir_d = 1'b0;
      end
      if (tick) begin
        if (!center) begin
          cnt_d = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
        end else if (period == '0) begin
          cnt_d = '0;
          dir_d = 1'b0;
        end else if (!dir_q) begin
          if (cnt_q >= period) begin
            // With P=1 the down leg is empty: go straight back to 0 counting up.
            if (period == WIDTH'(1)) begin
              cnt_d = '0;
              dir_d = 1'b0;
            end else begin
              cnt_d = period - 1'b1;
              dir_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q <= WIDTH'(1)) begin
            cnt_d = '0;
            dir_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

  // Duty double-buffer: shadow takes writes; active reloads from pre-write shadow at a boundary,
  // and follows shadow continuously while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!en || boundary) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_ok) begin
        shadow_q[wr_ch] <= wr_duty;
      end
    end
  end

  // Registered compare outputs and the one-clk period-start strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sout_q[i] <= en & (cnt_q < active_q[i]);
      end
      period_start_q <= boundary;
    end
  end

  assign sout         = sout_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center modes, double-buffered duties, prescale, enable and reset.
// Samples outputs on the falling clock edge; inputs change on the falling edge too.
// Each test task drives its own stimulus and compares against hand-computed values.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       center;
  logic [7:0] prescale;
  logic [7:0] period;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_duty;
  logic [3:0] sout;
  logic       period_start;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .center       (center),
    .prescale     (prescale),
    .period       (period),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .sout         (sout),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Single duty write, one clk wide.
  task automatic do_write(input logic [1:0] ch, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Disable, program mode/prescale/period and four duties, then enable.
  task automatic setup(input logic c, input logic [7:0] ps, input logic [7:0] p,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    @(negedge clk);
    en       = 1'b0;
    center   = c;
    prescale = ps;
    period   = p;
    do_write(2'd0, d0);
    do_write(2'd1, d1);
    do_write(2'd2, d2);
    do_write(2'd3, d3);
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
  endtask

  // Advance to the first sample with period_start high, bounded.
  task automatic wait_ps(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_sync: period_start seen=%0b required=1 within 200 clk", tag, found);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; center = 1'b0; prescale = 8'd0; period = 8'd9;
    wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sout !== 4'b0000) begin
      n_fail++; $display("FAIL reset_sout: got %b required 0000", sout);
    end
    n_cmp++;
    if (period_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ps: got %b required 0", period_start);
    end
    en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sout !== 4'b0000) begin
      n_fail++; $display("FAIL disabled_sout: got %b required 0000", sout);
    end
  endtask

  task automatic test_edge();
    int c[4];
    int psn;
    logic [9:0] pat0;
    logic [29:0] pspat;
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd10, 8'd5);
    wait_ps("edge");
    c = '{0, 0, 0, 0}; psn = 0; pat0 = '0; pspat = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) if (sout[ch]) c[ch]++;
      if (period_start) psn++;
      if (k <= 10) pat0[k-1] = sout[0];
      pspat[k-1] = period_start;
    end
    n_cmp++; if (c[0] !== 9)  begin n_fail++; $display("FAIL edge_ch0_high: got %0d required 9", c[0]); end
    n_cmp++; if (c[1] !== 0)  begin n_fail++; $display("FAIL edge_d0_high: got %0d required 0", c[1]); end
    n_cmp++; if (c[2] !== 30) begin n_fail++; $display("FAIL edge_dgtp_high: got %0d required 30", c[2]); end
    n_cmp++; if (c[3] !== 15) begin n_fail++; $display("FAIL edge_ch3_high: got %0d required 15", c[3]); end
    n_cmp++; if (psn !== 3)   begin n_fail++; $display("FAIL edge_ps_count: got %0d required 3", psn); end
    n_cmp++;
    if (pat0 !== 10'b0000000111) begin
      n_fail++; $display("FAIL edge_ch0_pattern: got %b required 0000000111", pat0);
    end
    n_cmp++;
    if (pspat !== 30'b100000000010000000001000000000) begin
      n_fail++; $display("FAIL edge_ps_spacing: got %b required every 10th", pspat);
    end
  endtask

  task automatic test_double_buffer();
    int c1, c2, c3;
    // Write mid-period: current period keeps the old duty.
    wait_ps("dbuf_mid");
    c1 = 0; c2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (sout[0]) begin
        if (k <= 10) c1++; else c2++;
      end
      if (k == 3) begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd7; end
    end
    n_cmp++; if (c1 !== 3) begin n_fail++; $display("FAIL dbuf_mid_cur: got %0d required 3", c1); end
    n_cmp++; if (c2 !== 7) begin n_fail++; $display("FAIL dbuf_mid_next: got %0d required 7", c2); end
    // Write landing exactly on the boundary clk: takes one extra period.
    wait_ps("dbuf_bnd");
    c1 = 0; c2 = 0; c3 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (sout[0]) begin
        if (k <= 10) c1++; else if (k <= 20) c2++; else c3++;
      end
      if (k == 9) begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd2; end
    end
    n_cmp++; if (c1 !== 7) begin n_fail++; $display("FAIL dbuf_bnd_p0: got %0d required 7", c1); end
    n_cmp++; if (c2 !== 7) begin n_fail++; $display("FAIL dbuf_bnd_p1: got %0d required 7", c2); end
    n_cmp++; if (c3 !== 2) begin n_fail++; $display("FAIL dbuf_bnd_p2: got %0d required 2", c3); end
  endtask

  task automatic test_center();
    logic [15:0] pat0, pat1, pat2, pat3, pspat;
    setup(1'b1, 8'd0, 8'd4, 8'd2, 8'd0, 8'd5, 8'd4);
    wait_ps("center");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      pat0[k-1]  = sout[0];
      pat1[k-1]  = sout[1];
      pat2[k-1]  = sout[2];
      pat3[k-1]  = sout[3];
      pspat[k-1] = period_start;
    end
    // cnt per sample: 0,1,2,3,4,3,2,1 repeating
    n_cmp++; if (pat0 !== 16'h8383)  begin n_fail++; $display("FAIL center_d2: got %h required 8383", pat0); end
    n_cmp++; if (pat1 !== 16'h0000)  begin n_fail++; $display("FAIL center_d0: got %h required 0000", pat1); end
    n_cmp++; if (pat2 !== 16'hFFFF)  begin n_fail++; $display("FAIL center_dgtp: got %h required ffff", pat2); end
    n_cmp++; if (pat3 !== 16'hEFEF)  begin n_fail++; $display("FAIL center_d4: got %h required efef", pat3); end
    n_cmp++; if (pspat !== 16'h8080) begin n_fail++; $display("FAIL center_ps: got %h required 8080", pspat); end
  endtask

  task automatic test_prescale();
    int c0, psn;
    logic [11:0] pat0;
    logic ps1, ps30;
    setup(1'b0, 8'd2, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0);
    wait_ps("prescale");
    c0 = 0; psn = 0; pat0 = '0; ps1 = 1'b0; ps30 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sout[0]) c0++;
      if (period_start) psn++;
      if (k <= 12) pat0[k-1] = sout[0];
      if (k == 1)  ps1  = period_start;
      if (k == 30) ps30 = period_start;
    end
    n_cmp++; if (c0 !== 18)  begin n_fail++; $display("FAIL pre_ch0_high: got %0d required 18", c0); end
    n_cmp++; if (psn !== 2)  begin n_fail++; $display("FAIL pre_ps_count: got %0d required 2", psn); end
    n_cmp++; if (ps1 !== 1'b0) begin n_fail++; $display("FAIL pre_ps_width: got %b required 0", ps1); end
    n_cmp++; if (ps30 !== 1'b1) begin n_fail++; $display("FAIL pre_ps_period: got %b required 1", ps30); end
    n_cmp++;
    if (pat0 !== 12'h1FF) begin
      n_fail++; $display("FAIL pre_ch0_pattern: got %h required 1ff", pat0);
    end
  endtask

  task automatic test_en_rst();
    logic [9:0] pat0, pspat;
    int c0, psn;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (sout !== 4'b0000) begin n_fail++; $display("FAIL en0_sout: got %b required 0000", sout); end
    n_cmp++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL en0_ps: got %b required 0", period_start); end
    prescale = 8'd0; period = 8'd9; center = 1'b0;
    do_write(2'd0, 8'd5);
    repeat (3) @(negedge clk);
    n_cmp++; if (sout !== 4'b0000) begin n_fail++; $display("FAIL en0_hold: got %b required 0000", sout); end
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat0[k]  = sout[0];
      pspat[k] = period_start;
    end
    n_cmp++; if (pat0 !== 10'b0000011111) begin n_fail++; $display("FAIL en_rise_pat: got %b required 0000011111", pat0); end
    n_cmp++; if (pspat !== 10'b1000000000) begin n_fail++; $display("FAIL en_rise_ps: got %b required 1000000000", pspat); end
    @(negedge clk);
    n_cmp++; if (sout[0] !== 1'b1) begin n_fail++; $display("FAIL pre_rst_high: got %b required 1", sout[0]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sout !== 4'b0000) begin n_fail++; $display("FAIL async_rst_sout: got %b required 0000", sout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = 0; psn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sout != 4'b0000) c0++;
      if (period_start) psn++;
    end
    n_cmp++; if (c0 !== 0)  begin n_fail++; $display("FAIL rst_duty_clear: got %0d high samples required 0", c0); end
    n_cmp++; if (psn !== 2) begin n_fail++; $display("FAIL rst_restart_ps: got %0d required 2", psn); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_double_buffer();
    test_center();
    test_prescale();
    test_en_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
